// File: rtl/monim_axil_ctl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | monim_axil_ctl : AXI4-Lite responder with CTL_1/CTL_2 control words,        |
// |                  P_SM_1/P_SM_2 readback and a constant ID register.          |
// | Optional: MONIM_CTL_SNAP_EN (coherent P_SM_1/P_SM_2 snapshot).              |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module monim_axil_ctl #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] ID_VALUE  = 32'h4D4F_4E31,
  parameter logic [31:0] CTL_1_RST = 32'h0,
  parameter logic [31:0] CTL_2_RST = 32'h0
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic [ADDR_W-1:0] s_awaddr_i,
  input  logic              s_awvalid_i,
  output logic              s_awready_o,
  input  logic [31:0]       s_wdata_i,
  input  logic [3:0]        s_wstrb_i,
  input  logic              s_wvalid_i,
  output logic              s_wready_o,
  output logic [1:0]        s_bresp_o,
  output logic              s_bvalid_o,
  input  logic              s_bready_i,
  input  logic [ADDR_W-1:0] s_araddr_i,
  input  logic              s_arvalid_i,
  output logic              s_arready_o,
  output logic [31:0]       s_rdata_o,
  output logic [1:0]        s_rresp_o,
  output logic              s_rvalid_o,
  input  logic              s_rready_i,
  input  logic [31:0]       p_sm_1_i,
  input  logic [31:0]       p_sm_2_i,
  output logic [31:0]       ctl_1_o,
  output logic [31:0]       ctl_2_o,
  output logic              ctl_upd_o
);

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  localparam logic [2:0] IDX_CTL_1 = 3'd0;
  localparam logic [2:0] IDX_CTL_2 = 3'd1;
  localparam logic [2:0] IDX_P_SM_1 = 3'd2;
  localparam logic [2:0] IDX_P_SM_2 = 3'd3;
  localparam logic [2:0] IDX_ID = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  // ---------------------------------------------------------------- write side
  logic [0:0]  w_state_q, w_state_d;
  logic        aw_held_q, w_held_q;
  logic [2:0]  aw_idx_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] ctl_1_q, ctl_2_q;
  logic [1:0]  bresp_q;
  logic        ctl_upd_q;

  logic        aw_hs, w_hs, wr_fire, wr_ok;
  logic [2:0]  wr_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) w_state_q <= W_IDLE;
    else        w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (wr_fire) w_state_d = W_RESP;
      W_RESP:  if (s_bready_i) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    s_awready_o = (w_state_q == W_IDLE) && !aw_held_q;
    s_wready_o  = (w_state_q == W_IDLE) && !w_held_q;
    s_bvalid_o  = (w_state_q == W_RESP);
  end

  // A channel handshaking this cycle counts as held, so the commit happens on
  // the edge that completes the pair rather than one cycle later.
  always_comb begin
    aw_hs   = s_awvalid_i && s_awready_o;
    w_hs    = s_wvalid_i && s_wready_o;
    wr_fire = (w_state_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
    wr_idx  = aw_held_q ? aw_idx_q : s_awaddr_i[4:2];
    wr_data = w_held_q ? wdata_q : s_wdata_i;
    wr_strb = w_held_q ? wstrb_q : s_wstrb_i;
    wr_ok   = (wr_idx == IDX_CTL_1) || (wr_idx == IDX_CTL_2);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= 3'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
    end else if (wr_fire) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        aw_idx_q  <= s_awaddr_i[4:2];
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        wdata_q  <= s_wdata_i;
        wstrb_q  <= s_wstrb_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      ctl_1_q   <= CTL_1_RST;
      ctl_2_q   <= CTL_2_RST;
      bresp_q   <= RESP_OKAY;
      ctl_upd_q <= 1'b0;
    end else begin
      ctl_upd_q <= wr_fire && wr_ok;
      if (wr_fire) begin
        bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (wr_idx == IDX_CTL_1) ctl_1_q <= apply_strb(ctl_1_q, wr_data, wr_strb);
        if (wr_idx == IDX_CTL_2) ctl_2_q <= apply_strb(ctl_2_q, wr_data, wr_strb);
      end
    end
  end

  assign s_bresp_o = bresp_q;
  assign ctl_1_o   = ctl_1_q;
  assign ctl_2_o   = ctl_2_q;
  assign ctl_upd_o = ctl_upd_q;

  // ----------------------------------------------------------------- read side
  logic [0:0]  r_state_q, r_state_d;
  logic [31:0] rdata_q, rd_data, p_sm_2_sel;
  logic [1:0]  rresp_q, rd_resp;
  logic        ar_hs;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) r_state_q <= R_IDLE;
    else        r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (s_arvalid_i) r_state_d = R_DATA;
      R_DATA:  if (s_rready_i) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    s_arready_o = (r_state_q == R_IDLE);
    s_rvalid_o  = (r_state_q == R_DATA);
  end

  assign ar_hs = s_arvalid_i && s_arready_o;

`ifdef MONIM_CTL_SNAP_EN
  logic [31:0] snap_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i)                                         snap_q <= 32'd0;
    else if (ar_hs && s_araddr_i[4:2] == IDX_P_SM_1)    snap_q <= p_sm_2_i;
  end

  assign p_sm_2_sel = snap_q;
`else
  assign p_sm_2_sel = p_sm_2_i;
`endif

  // Control registers are read before this edge's write lands, so a colliding
  // read returns the pre-write value.
  always_comb begin
    rd_data = 32'd0;
    rd_resp = RESP_OKAY;
    case (s_araddr_i[4:2])
      IDX_CTL_1:  rd_data = ctl_1_q;
      IDX_CTL_2:  rd_data = ctl_2_q;
      IDX_P_SM_1: rd_data = p_sm_1_i;
      IDX_P_SM_2: rd_data = p_sm_2_sel;
      IDX_ID:     rd_data = ID_VALUE;
      default:    rd_resp = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rdata_q <= 32'd0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= rd_data;
      rresp_q <= rd_resp;
    end
  end

  assign s_rdata_o = rdata_q;
  assign s_rresp_o = rresp_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_awaddr_i, s_araddr_i};

endmodule
`default_nettype wire

// File: tb/tb_monim_axil_ctl.sv
`default_nettype none
// Randomized bench for monim_axil_ctl with a transaction-level reference model.
// Honours MONIM_CTL_SNAP_EN the same way as the design.
module tb_monim_axil_ctl;

  localparam logic [31:0] ID_VAL = 32'h4D4F_4E31;

  logic        clk_i = 1'b0;
  logic        arst_i;
  logic [7:0]  s_awaddr_i = '0;
  logic        s_awvalid_i = 1'b0;
  logic        s_awready_o;
  logic [31:0] s_wdata_i = '0;
  logic [3:0]  s_wstrb_i = '0;
  logic        s_wvalid_i = 1'b0;
  logic        s_wready_o;
  logic [1:0]  s_bresp_o;
  logic        s_bvalid_o;
  logic        s_bready_i = 1'b1;
  logic [7:0]  s_araddr_i = '0;
  logic        s_arvalid_i = 1'b0;
  logic        s_arready_o;
  logic [31:0] s_rdata_o;
  logic [1:0]  s_rresp_o;
  logic        s_rvalid_o;
  logic        s_rready_i = 1'b1;
  logic [31:0] p_sm_1_i = '0;
  logic [31:0] p_sm_2_i = '0;
  logic [31:0] ctl_1_o;
  logic [31:0] ctl_2_o;
  logic        ctl_upd_o;

  monim_axil_ctl dut (
    .clk_i(clk_i), .arst_i(arst_i),
    .s_awaddr_i(s_awaddr_i), .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o),
    .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i), .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o),
    .s_bresp_o(s_bresp_o), .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i),
    .s_araddr_i(s_araddr_i), .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o),
    .s_rdata_o(s_rdata_o), .s_rresp_o(s_rresp_o), .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i),
    .p_sm_1_i(p_sm_1_i), .p_sm_2_i(p_sm_2_i),
    .ctl_1_o(ctl_1_o), .ctl_2_o(ctl_2_o), .ctl_upd_o(ctl_upd_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ------------------------------------------------ transaction-level model
  logic [31:0] m_ctl [2];
  logic        m_aw_have, m_w_have, m_bpend, m_rpend, m_upd;
  logic [7:0]  m_aw_addr;
  logic [31:0] m_wdata, m_rdata, m_snap;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;
  logic        hs_aw, hs_w, hs_ar;

  always @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      m_ctl[0] = 32'h0; m_ctl[1] = 32'h0;
      m_aw_have = 0; m_w_have = 0; m_bpend = 0; m_rpend = 0; m_upd = 0;
      m_aw_addr = 0; m_wdata = 0; m_wstrb = 0; m_rdata = 0; m_snap = 0;
      m_bresp = 0; m_rresp = 0;
      hs_aw = 0; hs_w = 0; hs_ar = 0;
    end else begin
      hs_ar = s_arvalid_i && !m_rpend;
      hs_aw = s_awvalid_i && !m_bpend && !m_aw_have;
      hs_w  = s_wvalid_i && !m_bpend && !m_w_have;
      // reads see the register contents from before any write on this edge
      if (m_rpend) begin
        if (s_rready_i) m_rpend = 0;
      end else if (hs_ar) begin
        m_rresp = 2'b00;
        case (s_araddr_i[4:2])
          3'd0: m_rdata = m_ctl[0];
          3'd1: m_rdata = m_ctl[1];
          3'd2: begin
            m_rdata = p_sm_1_i;
            m_snap  = p_sm_2_i;
          end
`ifdef MONIM_CTL_SNAP_EN
          3'd3: m_rdata = m_snap;
`else
          3'd3: m_rdata = p_sm_2_i;
`endif
          3'd4: m_rdata = ID_VAL;
          default: begin m_rdata = 32'h0; m_rresp = 2'b10; end
        endcase
        m_rpend = 1;
      end
      m_upd = 0;
      if (m_bpend) begin
        if (s_bready_i) m_bpend = 0;
      end else begin
        if (hs_aw) begin m_aw_have = 1; m_aw_addr = s_awaddr_i; end
        if (hs_w)  begin m_w_have = 1; m_wdata = s_wdata_i; m_wstrb = s_wstrb_i; end
        if (m_aw_have && m_w_have) begin
          if (m_aw_addr[4:2] < 3'd2) begin
            for (int b = 0; b < 4; b++)
              if (m_wstrb[b]) m_ctl[m_aw_addr[2]][8*b +: 8] = m_wdata[8*b +: 8];
            m_bresp = 2'b00;
            m_upd = 1;
          end else begin
            m_bresp = 2'b10;
          end
          m_bpend = 1; m_aw_have = 0; m_w_have = 0;
        end
      end
    end
  end

  // --------------------------------------------------- per-cycle comparison
  initial begin
    forever begin
      @(negedge clk_i);
      #1;
      if (ctl_upd_o) upd_cnt++;
      check("awready", 32'(s_awready_o), 32'(!m_bpend && !m_aw_have));
      check("wready",  32'(s_wready_o),  32'(!m_bpend && !m_w_have));
      check("arready", 32'(s_arready_o), 32'(!m_rpend));
      check("bvalid",  32'(s_bvalid_o),  32'(m_bpend));
      check("ctl_upd", 32'(ctl_upd_o),   32'(m_upd));
      check("rvalid",  32'(s_rvalid_o),  32'(m_rpend));
      check("ctl_1",   ctl_1_o, m_ctl[0]);
      check("ctl_2",   ctl_2_o, m_ctl[1]);
      if (m_bpend) check("bresp", 32'(s_bresp_o), 32'(m_bresp));
      if (m_rpend) begin
        check("rdata", s_rdata_o, m_rdata);
        check("rresp", 32'(s_rresp_o), 32'(m_rresp));
      end
      if (arst_i) begin
        check("rst_rdata", s_rdata_o, 32'h0);
        check("rst_bresp", 32'(s_bresp_o), 32'h0);
        check("rst_rresp", 32'(s_rresp_o), 32'h0);
      end
    end
  end

  // ------------------------------------------------------------------ drivers
  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int dly_aw, input int dly_w, input int bhold, output logic [1:0] resp);
    bit got_aw = 0;
    bit got_w = 0;
    int k = 0;
    s_bready_i = (bhold == 0);
    while (!(got_aw && got_w) && k < 60) begin
      @(negedge clk_i);
      if (s_awvalid_i && hs_aw) begin got_aw = 1; s_awvalid_i = 0; end
      if (s_wvalid_i && hs_w)   begin got_w = 1;  s_wvalid_i = 0; end
      if (k == dly_aw) begin s_awaddr_i = a; s_awvalid_i = 1; end
      if (k == dly_w)  begin s_wdata_i = d; s_wstrb_i = s; s_wvalid_i = 1; end
      k++;
    end
    if (!(got_aw && got_w)) begin
      check("wr_timeout", 32'(k), 32'(0));
      s_awvalid_i = 0; s_wvalid_i = 0; s_bready_i = 1; resp = 2'b11;
      return;
    end
    repeat (bhold) @(negedge clk_i);
    resp = s_bresp_o;
    s_bready_i = 1;
    @(negedge clk_i);
  endtask

  task automatic rd(input logic [7:0] a, input int hold, output logic [31:0] d, output logic [1:0] r);
    int k = 0;
    s_rready_i = (hold == 0);
    @(negedge clk_i);
    s_araddr_i = a;
    s_arvalid_i = 1;
    do begin @(negedge clk_i); k++; end while (!hs_ar && k < 60);
    s_arvalid_i = 0;
    if (!hs_ar) begin
      check("rd_timeout", 32'(k), 32'(0));
      s_rready_i = 1; d = 0; r = 2'b11;
      return;
    end
    repeat (hold) @(negedge clk_i);
    d = s_rdata_o;
    r = s_rresp_o;
    s_rready_i = 1;
    @(negedge clk_i);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [31:0] d;
  logic [1:0]  r, resp;
  int          c0;
  bit          rand_done = 0;

  initial begin
    arst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #2;
    check("rst_ctl_1", ctl_1_o, 32'h0);
    check("rst_ctl_2", ctl_2_o, 32'h0);
    check("rst_readies", 32'({s_awready_o, s_wready_o, s_arready_o}), 32'h7);
    @(negedge clk_i);
    arst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    rd(8'h10, 0, d, r);
    check("id_data", d, ID_VAL);
    check("id_resp", 32'(r), 32'h0);

    c0 = upd_cnt;
    wr(8'h00, 32'h1234_5678, 4'hF, 0, 1, 0, resp);
    check("ctl1_val", ctl_1_o, 32'h1234_5678);
    check("ctl1_resp", 32'(resp), 32'h0);
    check("ctl1_upd_once", 32'(upd_cnt - c0), 32'd1);

    wr(8'h04, 32'hAABB_CCDD, 4'hF, 1, 0, 0, resp);
    wr(8'h04, 32'h1122_3344, 4'b0101, 0, 0, 0, resp);
    check("ctl2_strb", ctl_2_o, 32'hAA22_CC44);

    c0 = upd_cnt;
    wr(8'h08, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, resp);
    check("ro_resp", 32'(resp), 32'h2);
    check("ro_no_upd", 32'(upd_cnt - c0), 32'd0);
    check("ro_ctl1", ctl_1_o, 32'h1234_5678);
    rd(8'h14, 0, d, r);
    check("unmap_data", d, 32'h0);
    check("unmap_resp", 32'(r), 32'h2);

    p_sm_1_i = 32'hCAFE_0001;
    fork
      rd(8'h08, 5, d, r);
      begin
        repeat (2) @(negedge clk_i);
        repeat (5) begin p_sm_1_i = $urandom; @(negedge clk_i); end
      end
      wr(8'h00, 32'h0BAD_F00D, 4'hF, 1, 2, 0, resp);
    join
    check("hold_rdata", d, 32'hCAFE_0001);
    check("hold_wr_ctl1", ctl_1_o, 32'h0BAD_F00D);

    fork
      wr(8'h00, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, resp);
      rd(8'h00, 0, d, r);
    join
    check("rw_collide_old", d, 32'h0BAD_F00D);
    check("rw_collide_new", ctl_1_o, 32'hDEAD_BEEF);

    c0 = upd_cnt;
    wr(8'h04, 32'h5555_5555, 4'h0, 0, 0, 0, resp);
    check("strb0_resp", 32'(resp), 32'h0);
    check("strb0_upd", 32'(upd_cnt - c0), 32'd1);
    check("strb0_ctl2", ctl_2_o, 32'hAA22_CC44);

    p_sm_2_i = 32'h55;
    rd(8'h08, 0, d, r);
    p_sm_2_i = 32'h66;
    rd(8'h0C, 0, d, r);
`ifdef MONIM_CTL_SNAP_EN
    check("snap_p_sm_2", d, 32'h55);
`else
    check("live_p_sm_2", d, 32'h66);
`endif

    // reset with a write address held and a read response outstanding
    @(negedge clk_i);
    s_awaddr_i = 8'h04; s_awvalid_i = 1; s_araddr_i = 8'h10; s_arvalid_i = 1; s_rready_i = 0;
    @(negedge clk_i);
    s_awvalid_i = 0; s_arvalid_i = 0;
    @(negedge clk_i);
    arst_i = 1;
    @(negedge clk_i);
    #2;
    check("mid_rst_ctl2", ctl_2_o, 32'h0);
    check("mid_rst_rvalid", 32'(s_rvalid_o), 32'h0);
    @(negedge clk_i);
    arst_i = 0; s_rready_i = 1;
    repeat (2) @(negedge clk_i);
    s_wdata_i = 32'hFFFF_FFFF; s_wstrb_i = 4'hF; s_wvalid_i = 1;
    @(negedge clk_i);
    s_wvalid_i = 0;
    repeat (3) @(negedge clk_i);
    check("mid_rst_no_b", 32'(s_bvalid_o), 32'h0);
    s_awaddr_i = 8'h04; s_awvalid_i = 1;
    @(negedge clk_i);
    s_awvalid_i = 0;
    #2;
    check("post_rst_b", 32'(s_bvalid_o), 32'h1);
    check("post_rst_ctl2", ctl_2_o, 32'hFFFF_FFFF);
    @(negedge clk_i);

    fork
      begin
        fork
          for (int i = 0; i < 150; i++) begin
            logic [7:0] a;
            a = $urandom_range(0, 1) ? {3'($urandom), 3'($urandom_range(0, 1)), 2'($urandom)}
                                     : 8'($urandom);
            wr(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 2), resp);
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
          end
          for (int j = 0; j < 150; j++) begin
            logic [31:0] rdv;
            logic [1:0]  rrv;
            rd(8'($urandom), $urandom_range(0, 3), rdv, rrv);
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
          end
        join
        rand_done = 1;
      end
      while (!rand_done) begin
        @(negedge clk_i);
        p_sm_1_i = $urandom;
        p_sm_2_i = $urandom;
      end
    join

    repeat (3) @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/monim_axil_ctl.md
Name: monim_axil_ctl

Overview:
AXI4-Lite slave (responder) for the monim subsystem. It carries the host-to-hardware direction: the host writes two 32-bit control words that drive downstream logic. It also gives the host read access to the registered p_sm_1/p_sm_2 data from monim_sm. The write and read channels are handled by two independent state machines.

Parameters:
ADDR_W, 8, AXI-Lite address width; only bits [4:2] are decoded, bits [1:0] are ignored.
ID_VALUE, 32'h4D4F_4E31, constant returned at the ID register.
CTL_1_RST, 32'h0, reset value of CTL_1.
CTL_2_RST, 32'h0, reset value of CTL_2.

Ports:
clk_i  in  1  the single clock; all logic is in this domain.
arst_i  in  1  reset, asynchronous, active-high.
s_awaddr_i  in  ADDR_W  write address.
s_awvalid_i  in  1  write address valid.
s_awready_o  out  1  write address ready.
s_wdata_i  in  32  write data.
s_wstrb_i  in  4  byte strobes.
s_wvalid_i  in  1  write data valid.
s_wready_o  out  1  write data ready.
s_bresp_o  out  2  write response; 2'b00 OKAY, 2'b10 SLVERR.
s_bvalid_o  out  1  write response valid.
s_bready_i  in  1  write response ready.
s_araddr_i  in  ADDR_W  read address.
s_arvalid_i  in  1  read address valid.
s_arready_o  out  1  read address ready.
s_rdata_o  out  32  read data.
s_rresp_o  out  2  read response.
s_rvalid_o  out  1  read data valid.
s_rready_i  in  1  read data ready.
p_sm_1_i  in  32  registered data from monim_sm.
p_sm_2_i  in  32  registered data from monim_sm.
ctl_1_o  out  32  control word 1.
ctl_2_o  out  32  control word 2.
ctl_upd_o  out  1  one-cycle pulse after any successful write to CTL_1 or CTL_2.

Behaviour:
- Register map (word offsets):
  - 0x00 CTL_1: read/write.
  - 0x04 CTL_2: read/write.
  - 0x08 P_SM_1: read-only.
  - 0x0C P_SM_2: read-only.
  - 0x10 ID: read-only.
  - Any other offset is unmapped.
- Reset values while arst_i is high:
  - ctl_1_o = CTL_1_RST, ctl_2_o = CTL_2_RST.
  - s_awready_o = 1, s_wready_o = 1, s_arready_o = 1.
  - s_bvalid_o = 0, s_rvalid_o = 0, ctl_upd_o = 0.
  - s_rdata_o = 0, s_bresp_o = 0, s_rresp_o = 0.
- Write FSM states are W_IDLE and W_RESP.
  - In W_IDLE, the AW and W channels are accepted independently, in either order or in the same cycle. Each is latched on its handshake.
  - After its own handshake, a channel drops its ready until the response completes.
  - Once both the address and the data are held, the register update and the move to W_RESP happen on the same clock edge; s_bvalid_o = 1 from the next cycle.
  - The update is byte-wise per s_wstrb_i. wstrb = 4'b0000 is a legal write with no effect: OKAY response, ctl_upd_o still pulses.
  - ctl_upd_o pulses in the cycle where s_bvalid_o first rises.
  - A write to a read-only or unmapped offset changes nothing, responds SLVERR, and does not pulse ctl_upd_o.
  - W_RESP holds bvalid and bresp stable until s_bready_i = 1, then returns to W_IDLE with both readies = 1.
  - Back-to-back writes: the minimum period is 2 cycles per write when bready is tied high.
- Read FSM states are R_IDLE and R_DATA.
  - In R_IDLE, s_arready_o = 1. On the AR handshake, rdata and rresp are captured from the register values of that cycle; rvalid = 1 on the next cycle.
  - A read of an unmapped offset returns rdata = 0 with SLVERR.
  - R_DATA holds rdata, rresp and rvalid stable until s_rready_i = 1, then returns to R_IDLE.
- A read and a write to the same register handshaking in the same cycle: the read returns the pre-write value.
- The read and write FSMs never stall each other.
- An assertion of arst_i mid-transaction aborts every pending handshake and restores the reset values; no response is issued for the aborted transaction.

Optional Feature:
MONIM_CTL_SNAP_EN
- Defined: a read of P_SM_1 also captures p_sm_2_i into an internal snapshot register. A following read of P_SM_2 returns the snapshot, giving a coherent pair. A read of P_SM_2 without a prior P_SM_1 read returns the snapshot's reset value of 0.
- Undefined: no snapshot register exists, and P_SM_2 returns the live p_sm_2_i sampled at its AR handshake.

Test Plan:
- Reset -> ctl_1_o = 0, ctl_2_o = 0; ID read returns 32'h4D4F_4E31 with OKAY; all three readies = 1.
- AW=0x00 one cycle before W=0x1234_5678 with wstrb=4'hF; bready=1 -> ctl_1_o = 0x1234_5678 with OKAY; ctl_upd_o pulses once, in the first bvalid cycle.
- CTL_2 = 0xAABB_CCDD, then a write of 0x1122_3344 with wstrb=4'b0101 -> ctl_2_o = 0xAA22_CC44.
- Write to 0x08, then read 0x14 -> write: SLVERR, no ctl change, no ctl_upd_o pulse; read: rdata = 0, SLVERR.
- rready held low for 5 cycles during a P_SM_1 read while p_sm_1_i changes -> rdata stays at the value sampled at the AR handshake; a simultaneous write completes unaffected.
- MONIM_CTL_SNAP_EN defined: read P_SM_1 with p_sm_2_i = 0x55, change p_sm_2_i to 0x66, read P_SM_2 -> 0x55. Undefined: same sequence -> 0x66.
